// File: rtl/alu_regfile_unit.sv
// SPARC-subset execution core: windowed 72-entry register file, combinational ALU
// with N/Z/V/C condition codes, and the trap-base (+4) address adder.
module alu_regfile_unit (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [31:0] Rin,
    input  logic [1:0]  CWP,
    input  logic [4:0]  RA,
    input  logic [4:0]  RB,
    input  logic [4:0]  RC,
    input  logic        RFE,
    output logic [31:0] Aout,
    output logic [31:0] Bout,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic [5:0]  opcode,
    input  logic        carry,
    output logic [31:0] result,
    output logic        N,
    output logic        Z,
    output logic        V,
    output logic        C,
    input  logic [31:0] tb_in,
    input  logic        TB_ADD,
    output logic [31:0] tb_out
);

    localparam int NPHYS = 72;

    logic [31:0] r_regs [0:NPHYS-1];

    logic [6:0]  w_pa;
    logic [6:0]  w_pb;
    logic [6:0]  w_pc;

    // Globals map straight through; windowed registers rotate by 16 per window
    // inside a 64-entry ring, so a window's ins alias the next window's outs.
    function automatic logic [6:0] phys_idx(input logic [4:0] r, input logic [1:0] w);
        logic [5:0] ring;
        begin
            ring = {w, 4'b0000} + {1'b0, r - 5'd8};
            if (r < 5'd8)
                phys_idx = {2'b00, r};
            else
                phys_idx = {1'b0, ring} + 7'd8;
        end
    endfunction

    assign w_pa = phys_idx(RA, CWP);
    assign w_pb = phys_idx(RB, CWP);
    assign w_pc = phys_idx(RC, CWP);

    assign Aout = (RA == 5'd0) ? 32'd0 : r_regs[w_pa];
    assign Bout = (RB == 5'd0) ? 32'd0 : r_regs[w_pb];

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < NPHYS; i++)
                r_regs[i] <= '0;
        end else if (!RFE && (RC != 5'd0)) begin
            r_regs[w_pc] <= Rin;
        end
    end

    logic [32:0]        w_sum;
    logic [32:0]        w_diff;
    logic               w_cin;
    logic signed [31:0] w_a_s;
    logic [31:0]        w_res;
    logic               w_v;
    logic               w_c;

    assign w_cin = carry & opcode[3];
    assign w_a_s = signed'(A_in);
    assign w_sum  = {1'b0, A_in} + {1'b0, B_in} + {32'd0, w_cin};
    assign w_diff = {1'b0, A_in} - {1'b0, B_in} - {32'd0, w_cin};

    // Bit 4 selects the cc variant, which computes identically to the base op.
    always_comb begin
        w_res = B_in;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (opcode)
            6'h00, 6'h10, 6'h08, 6'h18: begin
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (A_in[31] == B_in[31]) && (w_sum[31] != A_in[31]);
            end
            6'h04, 6'h14, 6'h0C, 6'h1C: begin
                w_res = w_diff[31:0];
                w_c   = w_diff[32];
                w_v   = (A_in[31] != B_in[31]) && (w_diff[31] != A_in[31]);
            end
            6'h01, 6'h11: w_res = A_in & B_in;
            6'h02, 6'h12: w_res = A_in | B_in;
            6'h03, 6'h13: w_res = A_in ^ B_in;
            6'h05, 6'h15: w_res = A_in & ~B_in;
            6'h06, 6'h16: w_res = A_in | ~B_in;
            6'h07, 6'h17: w_res = ~(A_in ^ B_in);
            6'h25:        w_res = A_in << B_in[4:0];
            6'h26:        w_res = A_in >> B_in[4:0];
            6'h27:        w_res = 32'(w_a_s >>> B_in[4:0]);
            default:      w_res = B_in;
        endcase
    end

    assign result = w_res;
    assign N      = w_res[31];
    assign Z      = (w_res == 32'd0);
    assign V      = w_v;
    assign C      = w_c;

    assign tb_out = TB_ADD ? tb_in : tb_in + 32'd4;

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Directed bench for alu_regfile_unit: register windows, reset, ALU vectors, trap adder.
module tb_alu_regfile_unit;

    logic        Clk = 1'b0;
    logic        Clr;
    logic [31:0] Rin;
    logic [1:0]  CWP;
    logic [4:0]  RA, RB, RC;
    logic        RFE;
    logic [31:0] Aout, Bout;
    logic [31:0] A_in, B_in;
    logic [5:0]  opcode;
    logic        carry;
    logic [31:0] result;
    logic        N, Z, V, C;
    logic [31:0] tb_in;
    logic        TB_ADD;
    logic [31:0] tb_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu_regfile_unit dut (
        .Clk(Clk), .Clr(Clr), .Rin(Rin), .CWP(CWP), .RA(RA), .RB(RB), .RC(RC),
        .RFE(RFE), .Aout(Aout), .Bout(Bout), .A_in(A_in), .B_in(B_in),
        .opcode(opcode), .carry(carry), .result(result), .N(N), .Z(Z), .V(V),
        .C(C), .tb_in(tb_in), .TB_ADD(TB_ADD), .tb_out(tb_out)
    );

    always #5 Clk = ~Clk;

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] w, input logic [4:0] r, input logic [31:0] d);
        @(negedge Clk);
        CWP = w; RC = r; Rin = d; RFE = 1'b0;
        @(posedge Clk);
        #1;
        RFE = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] w, input logic [4:0] r,
                      input logic [31:0] exp);
        CWP = w; RA = r; RB = r;
        #1;
        check32({tag, "_A"}, Aout, exp);
        check32({tag, "_B"}, Bout, exp);
    endtask

    task automatic alu(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin, input logic [31:0] er,
                       input logic [3:0] enzvc);
        opcode = op; A_in = a; B_in = b; carry = cin;
        #1;
        check32({tag, "_res"}, result, er);
        check32({tag, "_nzvc"}, {28'd0, N, Z, V, C}, {28'd0, enzvc});
    endtask

    initial begin
        Clr = 1'b1; RFE = 1'b1; Rin = '0; CWP = '0; RA = '0; RB = '0; RC = '0;
        A_in = '0; B_in = '0; opcode = '0; carry = 1'b0; tb_in = '0; TB_ADD = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        rd("rst_r17", 2'd0, 5'd17, 32'h0);

        wr(2'd0, 5'd17, 32'hFFFFFFFF);
        rd("pre_clr_r17", 2'd0, 5'd17, 32'hFFFFFFFF);
        // Clear with a concurrent write: the write must be dropped.
        @(negedge Clk);
        Clr = 1'b1; RFE = 1'b0; RC = 5'd18; Rin = 32'hAAAA5555;
        @(posedge Clk); #1;
        Clr = 1'b0; RFE = 1'b1;
        rd("clr_r17", 2'd0, 5'd17, 32'h0);
        rd("clr_r18", 2'd0, 5'd18, 32'h0);

        wr(2'd0, 5'd17, 32'h9E044012);
        wr(2'd0, 5'd18, 32'h9E044012);
        rd("wr_r17", 2'd0, 5'd17, 32'h9E044012);
        rd("wr_r18", 2'd0, 5'd18, 32'h9E044012);
        wr(2'd0, 5'd0, 32'h55555555);
        rd("wr_r0", 2'd0, 5'd0, 32'h0);

        // Read-during-write: old value before the edge, new value after.
        @(negedge Clk);
        CWP = 2'd0; RA = 5'd19; RC = 5'd19; Rin = 32'h11111111; RFE = 1'b0;
        #1;
        check32("rdw_before", Aout, 32'h0);
        @(posedge Clk); #1;
        RFE = 1'b1;
        check32("rdw_after", Aout, 32'h11111111);

        alu("add", 6'h00, 32'h9E044012, 32'h9E044012, 1'b0, 32'h3C088024, 4'b0011);
        wr(2'd0, 5'd15, 32'h3C088024);
        rd("wr_r15", 2'd0, 5'd15, 32'h3C088024);

        wr(2'd1, 5'd24, 32'h12345678);
        rd("win1in_win2out", 2'd2, 5'd8, 32'h12345678);
        rd("win1in_self", 2'd1, 5'd24, 32'h12345678);
        rd("win0_r24", 2'd0, 5'd24, 32'h0);
        wr(2'd3, 5'd24, 32'hCAFEF00D);
        rd("win3in_win0out", 2'd0, 5'd8, 32'hCAFEF00D);
        wr(2'd0, 5'd5, 32'h0000BEEF);
        rd("glob_w1", 2'd1, 5'd5, 32'h0000BEEF);
        rd("glob_w3", 2'd3, 5'd5, 32'h0000BEEF);

        alu("sub",    6'h04, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 4'b1001);
        alu("subcc_v",6'h14, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0010);
        alu("sra",    6'h27, 32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 4'b1000);
        alu("addx",   6'h08, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0101);
        alu("add_nocin", 6'h00, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 4'b0000);
        alu("addcc_v",6'h10, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1010);
        alu("subx",   6'h0C, 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 4'b1001);
        alu("and",    6'h01, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 4'b1000);
        alu("or",     6'h02, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 32'hFFFFF0F0, 4'b1000);
        alu("xor",    6'h03, 32'hFFFF0000, 32'hFFFF0000, 1'b0, 32'h00000000, 4'b0100);
        alu("andn",   6'h05, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 32'hFFFF0000, 4'b1000);
        alu("orn",    6'h06, 32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0100);
        alu("xnorcc", 6'h17, 32'h12345678, 32'h12345678, 1'b0, 32'hFFFFFFFF, 4'b1000);
        alu("sll",    6'h25, 32'h00000001, 32'h0000001F, 1'b0, 32'h80000000, 4'b1000);
        alu("sll_amt",6'h25, 32'h00000001, 32'h00000021, 1'b0, 32'h00000002, 4'b0000);
        alu("srl",    6'h26, 32'h80000000, 32'h0000001F, 1'b0, 32'h00000001, 4'b0000);
        alu("pass3f", 6'h3F, 32'h12345678, 32'hABCD0000, 1'b0, 32'hABCD0000, 4'b1000);
        alu("pass09", 6'h09, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0100);

        tb_in = 32'h00000800; TB_ADD = 1'b0; #1;
        check32("tb_add4", tb_out, 32'h00000804);
        TB_ADD = 1'b1; #1;
        check32("tb_pass", tb_out, 32'h00000800);
        tb_in = 32'hFFFFFFFC; TB_ADD = 1'b0; #1;
        check32("tb_wrap", tb_out, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
